// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage 16-bit pipeline.
// It arbitrates the single SRAM bus between instruction fetch and MEM-stage
// data accesses, resolves load-use and taken-branch hazards, and counts the
// cycles in which the pc is held.
//
// Parameters:
//   MEM_WAIT    cycles a MEM-stage data access occupies the SRAM bus (1..15)
//   CNT_W       width of the stall performance counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   mem_req      MEM-stage instruction accesses data memory
//   id_load_use  ID instruction sources the register loaded by EX
//   id_branch    branch taken, resolved in ID
//   cnt_clr      synchronous clear of stall_cnt
//   stall        per-register hold: [0] pc [1] if_id [2] id_ex [3] ex_mem [4] mem_wb
//   if_id_flush  load NOP into if_id this edge
//   id_ex_flush  load bubble into id_ex this edge
//   mem_wb_flush load bubble into mem_wb this edge
//   bus_grant    0 = IF owns SRAM, 1 = MEM owns SRAM
//   busy         access state machine is not idle
//   stall_cnt    saturating count of cycles with stall[0]=1
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req,
  input  logic             id_load_use,
  input  logic             id_branch,
  input  logic             cnt_clr,
  output logic [4:0]       stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             bus_grant,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MEMW = 1'b1;

  // The first HOLD cycle is spent in IDLE and the LAST cycle is spent at
  // wc=0, so the counter starts two below the total access length.
  localparam logic [3:0] WC_INIT = (MEM_WAIT > 1) ? 4'(MEM_WAIT - 2) : 4'd0;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0] state;
  logic [0:0] next_state;
  logic [3:0] wc;
  logic [3:0] next_wc;

  // Outputs are decoded combinationally from the current state and inputs
  // so each hold/flush takes effect on the very edge that ends this cycle.
  // Everything is forced low while reset is asserted so an access in
  // progress releases the bus immediately.
  always_comb begin
    next_state   = state;
    next_wc      = wc;
    stall        = 5'b00000;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    bus_grant    = 1'b0;
    busy         = 1'b0;

    case (state)
      S_IDLE: begin
        if (mem_req) begin
          bus_grant = 1'b1;
          if (MEM_WAIT == 1) begin
            stall       = 5'b00011;
            id_ex_flush = 1'b1;
          end else begin
            stall        = 5'b01111;
            mem_wb_flush = 1'b1;
            next_state   = S_MEMW;
            next_wc      = WC_INIT;
          end
        end else if (id_load_use) begin
          stall       = 5'b00011;
          id_ex_flush = 1'b1;
        end else if (id_branch) begin
          if_id_flush = 1'b1;
        end
      end

      S_MEMW: begin
        busy = 1'b1;
        // A dropped request mid-access is a protocol violation: release
        // everything and fall back to IDLE rather than hold the pipe.
        if (!mem_req) begin
          next_state = S_IDLE;
          next_wc    = 4'd0;
        end else if (wc != 4'd0) begin
          stall        = 5'b01111;
          mem_wb_flush = 1'b1;
          bus_grant    = 1'b1;
          next_wc      = wc - 4'd1;
        end else begin
          stall       = 5'b00011;
          id_ex_flush = 1'b1;
          bus_grant   = 1'b1;
          next_state  = S_IDLE;
        end
      end

      default: begin
        next_state = S_IDLE;
        next_wc    = 4'd0;
      end
    endcase

    if (!rst) begin
      stall        = 5'b00000;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      bus_grant    = 1'b0;
      busy         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wc    <= 4'd0;
    end else begin
      state <= next_state;
      wc    <= next_wc;
    end
  end

  // Clear wins over increment; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall[0] && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. Three instances with
// MEM_WAIT = 1, 3 and 4 share one set of inputs; each scenario checks the
// instance it targets. Expected output vectors are queued when the
// stimulus is driven and popped when the combinational outputs settle.
// Output vector layout: {stall[4:0], if_id_flush, id_ex_flush,
// mem_wb_flush, bus_grant, busy}.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        id_load_use;
  logic        id_branch;
  logic        cnt_clr;

  logic [4:0]  stall1, stall3, stall4;
  logic        iff1, iff3, iff4;
  logic        ief1, ief3, ief4;
  logic        mwf1, mwf3, mwf4;
  logic        gnt1, gnt3, gnt4;
  logic        busy1, busy3, busy4;
  logic [15:0] cnt1, cnt3, cnt4;

  logic [9:0]  obs1, obs3, obs4;

  logic [9:0]  sb[$];

  int          checks;
  int          passes;

  localparam logic [9:0] ZERO  = 10'b00000_0_0_0_0_0;
  localparam logic [9:0] HOLD0 = 10'b01111_0_0_1_1_0;
  localparam logic [9:0] HOLD1 = 10'b01111_0_0_1_1_1;
  localparam logic [9:0] LAST0 = 10'b00011_0_1_0_1_0;
  localparam logic [9:0] LAST1 = 10'b00011_0_1_0_1_1;
  localparam logic [9:0] LU    = 10'b00011_0_1_0_0_0;
  localparam logic [9:0] BR    = 10'b00000_1_0_0_0_0;

  // Stimulus encoding {mem_req, id_load_use, id_branch, cnt_clr}
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_CLR  = 4'b0001;
  localparam logic [3:0] S_MEM  = 4'b1000;
  localparam logic [3:0] S_LU   = 4'b0100;

  pipe_hazard_ctrl #(.MEM_WAIT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .id_load_use(id_load_use),
    .id_branch(id_branch), .cnt_clr(cnt_clr), .stall(stall1),
    .if_id_flush(iff1), .id_ex_flush(ief1), .mem_wb_flush(mwf1),
    .bus_grant(gnt1), .busy(busy1), .stall_cnt(cnt1)
  );

  pipe_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .id_load_use(id_load_use),
    .id_branch(id_branch), .cnt_clr(cnt_clr), .stall(stall3),
    .if_id_flush(iff3), .id_ex_flush(ief3), .mem_wb_flush(mwf3),
    .bus_grant(gnt3), .busy(busy3), .stall_cnt(cnt3)
  );

  pipe_hazard_ctrl #(.MEM_WAIT(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .id_load_use(id_load_use),
    .id_branch(id_branch), .cnt_clr(cnt_clr), .stall(stall4),
    .if_id_flush(iff4), .id_ex_flush(ief4), .mem_wb_flush(mwf4),
    .bus_grant(gnt4), .busy(busy4), .stall_cnt(cnt4)
  );

  assign obs1 = {stall1, iff1, ief1, mwf1, gnt1, busy1};
  assign obs3 = {stall3, iff3, ief3, mwf3, gnt3, busy3};
  assign obs4 = {stall4, iff4, ief4, mwf4, gnt4, busy4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later,
  // well clear of the rising edge that consumes them.
  task automatic apply_stimulus(input logic [3:0] s);
    @(negedge clk);
    mem_req     = s[3];
    id_load_use = s[2];
    id_branch   = s[1];
    cnt_clr     = s[0];
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] exp_v;
    rst         = 1'b0;
    mem_req     = 1'b1;
    id_load_use = 1'b0;
    id_branch   = 1'b1;
    cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (obs1 !== ZERO) $display("[TB] FAIL reset_out1: got %b expected %b", obs1, ZERO);
    else passes++;
    checks++;
    if (obs3 !== ZERO) $display("[TB] FAIL reset_out3: got %b expected %b", obs3, ZERO);
    else passes++;
    checks++;
    if (obs4 !== ZERO) $display("[TB] FAIL reset_out4: got %b expected %b", obs4, ZERO);
    else passes++;
    checks++;
    if (cnt1 !== 16'd0) $display("[TB] FAIL reset_cnt1: got %0d expected 0", cnt1);
    else passes++;
    checks++;
    if (cnt3 !== 16'd0) $display("[TB] FAIL reset_cnt3: got %0d expected 0", cnt3);
    else passes++;
    checks++;
    if (cnt4 !== 16'd0) $display("[TB] FAIL reset_cnt4: got %0d expected 0", cnt4);
    else passes++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.push_back(HOLD0);
    apply_stimulus(4'b1010);
    exp_v = sb.pop_front();
    checks++;
    if (obs3 !== exp_v) $display("[TB] FAIL reset_first_hold: got %b expected %b", obs3, exp_v);
    else passes++;
    apply_stimulus(S_NONE);
  endtask

  task automatic test_mem_wait3();
    logic [3:0] stim[5];
    logic [9:0] expv[5];
    logic [9:0] exp_v;
    stim = '{S_CLR, S_MEM, S_MEM, S_MEM, S_NONE};
    expv = '{ZERO, HOLD0, HOLD1, LAST1, ZERO};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(expv[i]);
      apply_stimulus(stim[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs3 !== exp_v) $display("[TB] FAIL mw3_cycle%0d: got %b expected %b", i, obs3, exp_v);
      else passes++;
    end
    checks++;
    if (cnt3 !== 16'd3) $display("[TB] FAIL mw3_cnt: got %0d expected 3", cnt3);
    else passes++;
  endtask

  task automatic test_mem_wait1();
    logic [3:0] stim[5];
    logic [9:0] expv[5];
    logic [9:0] exp_v;
    stim = '{S_CLR, S_MEM, S_MEM, S_LU, S_NONE};
    expv = '{ZERO, LAST0, LAST0, LU, ZERO};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(expv[i]);
      apply_stimulus(stim[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs1 !== exp_v) $display("[TB] FAIL mw1_cycle%0d: got %b expected %b", i, obs1, exp_v);
      else passes++;
    end
    checks++;
    if (cnt1 !== 16'd3) $display("[TB] FAIL mw1_cnt: got %0d expected 3", cnt1);
    else passes++;
  endtask

  task automatic test_priority();
    logic [3:0] stim[6];
    logic [9:0] expv[6];
    logic [9:0] exp_v;
    stim = '{4'b0110, 4'b0010, 4'b1110, 4'b1110, 4'b1110, S_NONE};
    expv = '{LU, BR, HOLD0, HOLD1, LAST1, ZERO};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(expv[i]);
      apply_stimulus(stim[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs3 !== exp_v) $display("[TB] FAIL prio_cycle%0d: got %b expected %b", i, obs3, exp_v);
      else passes++;
    end
  endtask

  // Dropping mem_req mid-access: stall/flush/grant all low, and the next
  // request is treated as a fresh access from IDLE.
  task automatic test_protocol_violation();
    logic [3:0] stim[4];
    logic [9:0] expv[4];
    logic [9:0] exp_v;
    stim = '{S_MEM, S_NONE, S_MEM, S_NONE};
    expv = '{HOLD0, ZERO, HOLD0, ZERO};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(expv[i]);
      apply_stimulus(stim[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs4[9:1] !== exp_v[9:1])
        $display("[TB] FAIL viol_cycle%0d: got %b expected %b", i, obs4[9:1], exp_v[9:1]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] stim[7];
    logic [9:0] expv[7];
    logic [9:0] exp_v;
    stim = '{S_MEM, S_MEM, S_MEM, S_MEM, S_MEM, S_MEM, S_NONE};
    expv = '{HOLD0, HOLD1, LAST1, HOLD0, HOLD1, LAST1, ZERO};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(expv[i]);
      apply_stimulus(stim[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs3 !== exp_v) $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", i, obs3, exp_v);
      else passes++;
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] expv[5];
    logic [9:0] exp_v;
    sb.push_back(HOLD0);
    apply_stimulus(S_MEM);
    exp_v = sb.pop_front();
    checks++;
    if (obs4 !== exp_v) $display("[TB] FAIL abort_hold1: got %b expected %b", obs4, exp_v);
    else passes++;
    sb.push_back(HOLD1);
    apply_stimulus(S_MEM);
    exp_v = sb.pop_front();
    checks++;
    if (obs4 !== exp_v) $display("[TB] FAIL abort_hold2: got %b expected %b", obs4, exp_v);
    else passes++;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (obs4 !== ZERO) $display("[TB] FAIL abort_outputs: got %b expected %b", obs4, ZERO);
    else passes++;
    checks++;
    if (cnt4 !== 16'd0) $display("[TB] FAIL abort_cnt: got %0d expected 0", cnt4);
    else passes++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    expv = '{HOLD0, HOLD1, HOLD1, LAST1, ZERO};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(expv[i]);
      apply_stimulus((i < 4) ? S_MEM : S_NONE);
      exp_v = sb.pop_front();
      checks++;
      if (obs4 !== exp_v) $display("[TB] FAIL abort_restart%0d: got %b expected %b", i, obs4, exp_v);
      else passes++;
    end
  endtask

  task automatic test_saturation();
    logic [9:0] exp_v;
    apply_stimulus(S_CLR);
    repeat (65535) apply_stimulus(S_LU);
    apply_stimulus(S_NONE);
    checks++;
    if (cnt1 !== 16'hFFFF) $display("[TB] FAIL sat_fill: got %h expected ffff", cnt1);
    else passes++;
    apply_stimulus(S_LU);
    apply_stimulus(S_LU);
    apply_stimulus(S_NONE);
    checks++;
    if (cnt1 !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h expected ffff", cnt1);
    else passes++;
    sb.push_back(LU);
    apply_stimulus(4'b0101);
    exp_v = sb.pop_front();
    checks++;
    if (obs1 !== exp_v) $display("[TB] FAIL sat_clr_out: got %b expected %b", obs1, exp_v);
    else passes++;
    apply_stimulus(S_NONE);
    checks++;
    if (cnt1 !== 16'd0) $display("[TB] FAIL sat_clr: got %h expected 0000", cnt1);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_mem_wait3();
    test_mem_wait1();
    test_priority();
    test_protocol_violation();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
